// File: rtl/base64_pkg.sv
// Shared constants and the index-to-character map for the serial Base64 converter.
package base64_pkg;

    // Bits per Base64 symbol.
    localparam int GROUP_W = 6;

    // First index of each alphabet range.
    localparam logic [5:0] IDX_LOWER = 6'd26;
    localparam logic [5:0] IDX_DIGIT = 6'd52;
    localparam logic [5:0] IDX_PLUS  = 6'd62;
    localparam logic [5:0] IDX_SLASH = 6'd63;

    // Maps a 6-bit Base64 index to its ASCII character.
    function automatic logic [7:0] idx_to_ascii(input logic [5:0] idx);
        logic [7:0] ch;
        if (idx < IDX_LOWER) begin
            ch = 8'h41 + {2'b00, idx};
        end else if (idx < IDX_DIGIT) begin
            ch = 8'h61 + {2'b00, idx - IDX_LOWER};
        end else if (idx < IDX_PLUS) begin
            ch = 8'h30 + {2'b00, idx - IDX_DIGIT};
        end else if (idx == IDX_PLUS) begin
            ch = 8'h2B;
        end else begin
            ch = 8'h2F;
        end
        return ch;
    endfunction

endpackage

// File: rtl/base64_ascii_lut.sv
// Combinational Base64 index-to-ASCII map.
// Only instantiated when BASE64_ASCII_EN is defined.
module base64_ascii_lut
    import base64_pkg::*;
(
    input  logic [5:0] idx_i,
    output logic [7:0] ascii_o
);

    // Pure lookup; the caller registers the result.
    assign ascii_o = idx_to_ascii(idx_i);

endmodule

// File: rtl/serial_base64_converter.sv
// Bit-serial to Base64 converter: packs 6 MSB-first bits per symbol and
// strobes complete for one clock when each symbol lands in base64.
// Optional macro BASE64_ASCII_EN adds a registered ASCII character output.
module serial_base64_converter #(
    parameter int GROUP_W = base64_pkg::GROUP_W,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
`ifdef BASE64_ASCII_EN
    output logic [7:0]         ascii,
`endif
    output logic [GROUP_W-1:0] base64,
    output logic               complete
);

    // Counter value at which the incoming bit is the last of its group.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(GROUP_W - 1);

    // Only the first GROUP_W-1 bits need storing; the last one comes straight from din.
    logic [GROUP_W-2:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GROUP_W-1:0] base64_q, base64_d;
    logic               complete_q, complete_d;

    // Next-state: accumulate bits, publish the group on its final bit.
    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        base64_d   = base64_q;
        complete_d = 1'b0;
        if (cnt_q == LAST_BIT) begin
            base64_d   = {shift_q, din};
            complete_d = 1'b1;
            cnt_d      = '0;
            shift_d    = '0;
        end else begin
            shift_d = {shift_q[GROUP_W-3:0], din};
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // State registers, cleared immediately whenever rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            base64_q   <= '0;
            complete_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            base64_q   <= base64_d;
            complete_q <= complete_d;
        end
    end

    assign base64   = base64_q;
    assign complete = complete_q;

`ifdef BASE64_ASCII_EN
    logic [7:0] ascii_q, ascii_d;

    // Character is derived from the next symbol so it lands on the same edge.
    base64_ascii_lut u_ascii_lut (
        .idx_i   (base64_d),
        .ascii_o (ascii_d)
    );

    // ASCII register; reset value 'A' matches base64 = 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ascii_q <= 8'h41;
        end else begin
            ascii_q <= ascii_d;
        end
    end

    assign ascii = ascii_q;
`endif

endmodule

// File: tb/tb_serial_base64_converter.sv
// Randomised and directed bench for serial_base64_converter with a
// bit-counting reference model.
module tb_serial_base64_converter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic [5:0] base64;
    logic       complete;
`ifdef BASE64_ASCII_EN
    logic [7:0] ascii;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: bits since reset, last six bits, last published symbol.
    int         m_nbits;
    int         m_window;
    logic [5:0] m_b64;
    logic       m_complete;

    always #5 clk = ~clk;

    serial_base64_converter dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
`ifdef BASE64_ASCII_EN
        .ascii    (ascii),
`endif
        .base64   (base64),
        .complete (complete)
    );

`ifdef BASE64_ASCII_EN
    function automatic logic [7:0] ref_ascii(input logic [5:0] v);
        string alpha;
        alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";
        return alpha[v];
    endfunction
`endif

    function automatic void model_reset();
        m_nbits    = 0;
        m_window   = 0;
        m_b64      = 6'd0;
        m_complete = 1'b0;
    endfunction

    // Every sixth bit since reset completes a symbol made of the last six bits.
    function automatic void model_push(input logic b);
        m_nbits    = m_nbits + 1;
        m_window   = ((m_window * 2) + int'(b)) % 64;
        m_complete = (m_nbits % 6 == 0);
        if (m_complete) m_b64 = 6'(m_window);
    endfunction

    // Drives one bit at a falling edge; returns at the next falling edge.
    task automatic step(input logic b);
        din = b;
        @(negedge clk);
        model_push(b);
    endtask

    // Asserts reset away from clock edges, then releases it at a falling edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        int pulses;
        pulses = 0;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            din = 1'b1;
            @(negedge clk);
            if (complete) pulses++;
        end
        checks++;
        if (base64 !== 6'd0) begin
            errors++;
            $display("FAIL reset_base64 got=%0d want=0", base64);
        end
        checks++;
        if (complete !== 1'b0 || pulses != 0) begin
            errors++;
            $display("FAIL reset_complete got=%b pulses=%0d want=0", complete, pulses);
        end
`ifdef BASE64_ASCII_EN
        checks++;
        if (ascii !== 8'h41) begin
            errors++;
            $display("FAIL reset_ascii got=%h want=41", ascii);
        end
`endif
        rst = 1'b1;
        $display("test_reset: base64=%0d complete=%b", base64, complete);
    endtask

    task automatic test_pattern();
        logic [17:0] pat;
        int          pulse_at[$];
        pat = 18'b100001_110011_111001;
        for (int i = 17; i >= 0; i--) begin
            step(pat[i]);
            checks++;
            if (complete !== m_complete || base64 !== m_b64) begin
                errors++;
                $display("FAIL pattern_bit%0d got=%0d/%b want=%0d/%b", 17 - i, base64, complete, m_b64, m_complete);
            end
            if (complete) pulse_at.push_back(17 - i);
        end
        checks++;
        if (pulse_at.size() != 3 || m_b64 != 6'd57) begin
            errors++;
            $display("FAIL pattern_pulses got=%0d want=3", pulse_at.size());
        end else if (pulse_at[1] - pulse_at[0] != 6 || pulse_at[2] - pulse_at[1] != 6) begin
            errors++;
            $display("FAIL pattern_spacing got=%0d,%0d want=6,6", pulse_at[1] - pulse_at[0], pulse_at[2] - pulse_at[1]);
        end
`ifdef BASE64_ASCII_EN
        checks++;
        if (ascii !== 8'h35 || ref_ascii(6'd57) !== 8'h35) begin
            errors++;
            $display("FAIL pattern_ascii got=%h want=35", ascii);
        end
`endif
        $display("test_pattern: last base64=%0d pulses=%0d", base64, pulse_at.size());
    endtask

    task automatic test_all_ones();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1);
            checks++;
            if (complete !== m_complete || base64 !== m_b64) begin
                errors++;
                $display("FAIL ones_bit%0d got=%0d/%b want=%0d/%b", i, base64, complete, m_b64, m_complete);
            end
            if (complete) pulses++;
        end
        checks++;
        if (pulses != 2 || base64 !== 6'd63) begin
            errors++;
            $display("FAIL ones_result got=%0d pulses=%0d want=63 pulses=2", base64, pulses);
        end
`ifdef BASE64_ASCII_EN
        checks++;
        if (ascii !== ref_ascii(6'd63)) begin
            errors++;
            $display("FAIL ones_ascii got=%h want=%h", ascii, ref_ascii(6'd63));
        end
`endif
        $display("test_all_ones: base64=%0d pulses=%0d", base64, pulses);
    endtask

    task automatic test_reset_mid_group();
        logic [5:0] pat;
        int         pulses;
        pulses = 0;
        step(1'b1);
        step(1'b0);
        step(1'b1);
        // Asynchronous clear must be visible before any clock edge.
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (base64 !== 6'd0 || complete !== 1'b0) begin
            errors++;
            $display("FAIL async_clear got=%0d/%b want=0/0", base64, complete);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        pat = 6'b000110;
        for (int i = 5; i >= 0; i--) begin
            step(pat[i]);
            if (complete) pulses++;
            checks++;
            if (complete !== m_complete || base64 !== m_b64) begin
                errors++;
                $display("FAIL midreset_bit%0d got=%0d/%b want=%0d/%b", 5 - i, base64, complete, m_b64, m_complete);
            end
        end
        checks++;
        if (pulses != 1 || base64 !== 6'd6) begin
            errors++;
            $display("FAIL midreset_result got=%0d pulses=%0d want=6 pulses=1", base64, pulses);
        end
`ifdef BASE64_ASCII_EN
        checks++;
        if (ascii !== 8'h47) begin
            errors++;
            $display("FAIL midreset_ascii got=%h want=47", ascii);
        end
`endif
        $display("test_reset_mid_group: base64=%0d pulses=%0d", base64, pulses);
    endtask

    task automatic test_all_zeros();
        for (int i = 0; i < 6; i++) begin
            step(1'b0);
            checks++;
            if (complete !== m_complete || base64 !== m_b64) begin
                errors++;
                $display("FAIL zeros_bit%0d got=%0d/%b want=%0d/%b", i, base64, complete, m_b64, m_complete);
            end
        end
        checks++;
        if (base64 !== 6'd0 || complete !== 1'b1) begin
            errors++;
            $display("FAIL zeros_result got=%0d/%b want=0/1", base64, complete);
        end
`ifdef BASE64_ASCII_EN
        checks++;
        if (ascii !== 8'h41) begin
            errors++;
            $display("FAIL zeros_ascii got=%h want=41", ascii);
        end
`endif
        $display("test_all_zeros: base64=%0d complete=%b", base64, complete);
    endtask

    task automatic test_back_to_back();
        logic       b;
        int         pulses;
        int         last_pulse;
        logic [5:0] held;
        pulses     = 0;
        last_pulse = -1;
        do_reset();
        for (int i = 0; i < 98; i++) begin
            b = 1'($urandom_range(1, 0));
            step(b);
            checks++;
            if (complete !== m_complete || base64 !== m_b64) begin
                errors++;
                $display("FAIL stream_bit%0d got=%0d/%b want=%0d/%b", i, base64, complete, m_b64, m_complete);
            end
`ifdef BASE64_ASCII_EN
            checks++;
            if (ascii !== ref_ascii(m_b64)) begin
                errors++;
                $display("FAIL stream_ascii%0d got=%h want=%h", i, ascii, ref_ascii(m_b64));
            end
`endif
            if (complete) begin
                if (last_pulse >= 0) begin
                    checks++;
                    if (i - last_pulse != 6) begin
                        errors++;
                        $display("FAIL stream_gap got=%0d want=6", i - last_pulse);
                    end
                end
                last_pulse = i;
                pulses++;
            end
        end
        checks++;
        if (pulses != 16) begin
            errors++;
            $display("FAIL stream_pulses got=%0d want=16", pulses);
        end
        // Trailing partial group: three more bits still leave it short of six.
        held = m_b64;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            checks++;
            if (complete !== 1'b0 || base64 !== held) begin
                errors++;
                $display("FAIL stream_tail%0d got=%0d/%b want=%0d/0", i, base64, complete, held);
            end
        end
        $display("test_back_to_back: pulses=%0d final base64=%0d", pulses, base64);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pattern();
        test_all_ones();
        test_reset_mid_group();
        test_all_zeros();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
